pipelined_chunk_adder: RTL and testbench

//  Parametrised, pipelined add/subtract unit. WIDTH-bit operands split into CHUNK-bit slices;
//  one slice resolved per stage, carry registered between stages (one full_adder ripple per slice).

---
 rtl/adder_pkg.sv | 11 +
 rtl/chunk_add_stage.sv | 38 +++
 rtl/pipelined_chunk_adder.sv | 120 ++++++++++++
 tb/tb_pipelined_chunk_adder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - default geometry and stage-count helper for the chunked adder
package adder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CHUNK = 4;

    function automatic int nstg(input int w, input int c);
        return w / c;
    endfunction

endpackage

// File: rtl/chunk_add_stage.sv
// rtl/chunk_add_stage.sv - combinational CHUNK-bit ripple of full adders, one per pipeline stage
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_add_stage
    import adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = cin;
    assign cout   = w_c[CHUNK];

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_c[i]),
            .s  (s[i]),
            .co (w_c[i+1])
        );
    end
endmodule

// File: rtl/pipelined_chunk_adder.sv
// rtl/pipelined_chunk_adder.sv - pipelined add/sub, one CHUNK slice per stage; OVF_FLAG_EN adds signed overflow output V
module pipelined_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
`ifdef OVF_FLAG_EN
    output logic             V,
`endif
    output logic             Cout
);
    localparam int NSTG = nstg(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("pipelined_chunk_adder: WIDTH must be a multiple of CHUNK");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_a_in [NSTG];
    logic [WIDTH-1:0] w_b_in [NSTG];
    logic [WIDTH-1:0] w_s_in [NSTG];
    logic [WIDTH-1:0] w_s_nx [NSTG];
    logic             w_c_in [NSTG];
    logic             w_c_nx [NSTG];
    logic             w_vld_in [NSTG];

    logic [WIDTH-1:0] r_a [NSTG];
    logic [WIDTH-1:0] r_b [NSTG];
    logic [WIDTH-1:0] r_s [NSTG];
    logic             r_c [NSTG];
    logic             r_vld [NSTG];

    // Global stall: every stage moves together or nothing moves.
    assign w_adv     = !r_vld[NSTG-1] | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld[NSTG-1];
    assign Sum       = r_s[NSTG-1];
    assign Cout      = r_c[NSTG-1];

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [CHUNK-1:0] w_slice;

        if (k == 0) begin : g_first
            assign w_a_in[0]   = A;
            assign w_b_in[0]   = Sub ? ~B : B;
            assign w_c_in[0]   = Sub;
            assign w_s_in[0]   = '0;
            assign w_vld_in[0] = in_valid;
        end else begin : g_next
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_c_in[k]   = r_c[k-1];
            assign w_s_in[k]   = r_s[k-1];
            assign w_vld_in[k] = r_vld[k-1];
        end

        chunk_add_stage #(.CHUNK(CHUNK)) u_add (
            .a    (w_a_in[k][k*CHUNK +: CHUNK]),
            .b    (w_b_in[k][k*CHUNK +: CHUNK]),
            .cin  (w_c_in[k]),
            .s    (w_slice),
            .cout (w_c_nx[k])
        );

        // Bits at and above slice k are still zero in the partial sum, so OR merges.
        assign w_s_nx[k] = w_s_in[k] | (WIDTH'(w_slice) << (k*CHUNK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NSTG; k++) begin
                r_vld[k] <= w_vld_in[k];
                r_a[k]   <= w_a_in[k];
                r_b[k]   <= w_b_in[k];
                r_s[k]   <= w_s_nx[k];
                r_c[k]   <= w_c_nx[k];
            end
        end
    end

`ifdef OVF_FLAG_EN
    logic r_v;
    logic w_v_nx;

    assign w_v_nx = (w_a_in[NSTG-1][WIDTH-1] == w_b_in[NSTG-1][WIDTH-1]) &
                    (w_s_nx[NSTG-1][WIDTH-1] != w_a_in[NSTG-1][WIDTH-1]);
    assign V      = r_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= 1'b0;
        end else if (w_adv) begin
            r_v <= w_v_nx;
        end
    end
`endif

    logic w_unused;
    assign w_unused = ^{r_a[NSTG-1], r_b[NSTG-1]};

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// tb/tb_pipelined_chunk_adder.sv - scoreboard bench for 8/4 and 32/8 pipelined_chunk_adder builds
module tb_pipelined_chunk_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        v;
        int          t;
        bit          chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv8, ir8, sub8, ov8, or8, c8, v8;
    logic [7:0]  a8, b8, s8;
    logic        iv32, ir32, sub32, ov32, or32, c32, v32;
    logic [31:0] a32, b32, s32;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   chk_lat = 1'b1;
    exp_t q8[$];
    exp_t q32[$];
    exp_t e8_nx, e32_nx, m8, m32;

    logic [7:0] t4a [4] = '{8'h01, 8'hFF, 8'h55, 8'hC8};
    logic [7:0] t4b [4] = '{8'h02, 8'h01, 8'h0A, 8'h64};
    logic       t4u [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] t4s [4] = '{8'h03, 8'h00, 8'h4B, 8'h2C};
    logic       t4c [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .Sub(sub8),
        .out_valid(ov8), .out_ready(or8), .Sum(s8),
`ifdef OVF_FLAG_EN
        .V(v8),
`endif
        .Cout(c8)
    );

    pipelined_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .A(a32), .B(b32), .Sub(sub32),
        .out_valid(ov32), .out_ready(or32), .Sum(s32),
`ifdef OVF_FLAG_EN
        .V(v32),
`endif
        .Cout(c32)
    );

`ifndef OVF_FLAG_EN
    assign v8  = 1'b0;
    assign v32 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub, input int w);
        exp_t        e;
        logic [31:0] mask, bb, am;
        logic [32:0] tot;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        am     = a & mask;
        bb     = (sub ? ~b : b) & mask;
        tot    = {1'b0, am} + {1'b0, bb} + {32'd0, sub};
        e.sum  = tot[31:0] & mask;
        e.cout = tot[w];
        e.v    = (am[w-1] == bb[w-1]) && (e.sum[w-1] != am[w-1]);
        e.t    = 0;
        e.chk  = 1'b0;
        return e;
    endfunction

    task automatic push_both();
        if (iv8 && ir8) begin
            e8_nx.t = cyc; e8_nx.chk = chk_lat; q8.push_back(e8_nx);
        end
        if (iv32 && ir32) begin
            e32_nx.t = cyc; e32_nx.chk = chk_lat; q32.push_back(e32_nx);
        end
    endtask

    task automatic drv8(input bit v, input logic [7:0] a, input logic [7:0] b, input bit s,
                        input bit rdy, input logic [7:0] es, input bit ec, input bit ev, output bit acc);
        @(posedge clk); #1;
        iv8 = v; a8 = a; b8 = b; sub8 = s; or8 = rdy;
        iv32 = 1'b0; or32 = 1'b1;
        e8_nx.sum = {24'd0, es}; e8_nx.cout = ec; e8_nx.v = ev;
        @(negedge clk);
        acc = iv8 && ir8;
        push_both();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drv8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, acc);
    endtask

    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) chk("out8_unexpected", 64'd1, 64'd0);
            else begin
                m8 = q8.pop_front();
                chk("sum8", {56'd0, s8}, {32'd0, m8.sum});
                chk("cout8", {63'd0, c8}, {63'd0, m8.cout});
`ifdef OVF_FLAG_EN
                chk("v8", {63'd0, v8}, {63'd0, m8.v});
`endif
                if (m8.chk) chk("lat8", 64'(cyc - m8.t), 64'd2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov32 && or32) begin
            if (q32.size() == 0) chk("out32_unexpected", 64'd1, 64'd0);
            else begin
                m32 = q32.pop_front();
                chk("sum32", {32'd0, s32}, {32'd0, m32.sum});
                chk("cout32", {63'd0, c32}, {63'd0, m32.cout});
`ifdef OVF_FLAG_EN
                chk("v32", {63'd0, v32}, {63'd0, m32.v});
`endif
                if (m32.chk) chk("lat32", 64'(cyc - m32.t), 64'd4);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         acc;
        int         idx;
        int         n;
        logic [7:0] held_s;
        logic       held_c;

        rst = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; or8 = 1'b1;
        iv32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; or32 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {63'd0, ov8}, 64'd0);
        chk("rst_sum", {56'd0, s8}, 64'd0);
        chk("rst_cout", {63'd0, c8}, 64'd0);
        chk("rst_in_ready", {63'd0, ir8}, 64'd1);
        chk("rst_out_valid32", {63'd0, ov32}, 64'd0);
`ifdef OVF_FLAG_EN
        chk("rst_v", {63'd0, v8}, 64'd0);
`endif

        // Directed values, latency 2 checked by the monitor.
        drv8(1, 8'h92, 8'hAC, 0, 1, 8'h3E, 1, 1, acc);
        idle(3);
        drv8(1, 8'hEA, 8'h92, 0, 1, 8'h7C, 1, 1, acc);
        drv8(1, 8'h10, 8'h01, 1, 1, 8'h0F, 1, 0, acc);
        drv8(1, 8'h00, 8'h01, 1, 1, 8'hFF, 0, 0, acc);
`ifdef OVF_FLAG_EN
        drv8(1, 8'h7F, 8'h01, 0, 1, 8'h80, 0, 1, acc);
        drv8(1, 8'h80, 8'h01, 1, 1, 8'h7F, 1, 1, acc);
`endif
        idle(4);

        // Backpressure: out_ready low for three cycles while the first result waits.
        chk_lat = 1'b0;
        idx = 0;
        held_s = '0; held_c = 1'b0;
        for (int c = 0; c < 12; c++) begin
            bit rdy;
            rdy = !(c >= 2 && c <= 4);
            if (idx < 4) drv8(1, t4a[idx], t4b[idx], t4u[idx], rdy, t4s[idx], t4c[idx], 1'b0, acc);
            else drv8(0, 8'h00, 8'h00, 0, rdy, 8'h00, 0, 0, acc);
            if (acc) idx++;
            if (!rdy) begin
                chk("t4_in_ready", {63'd0, ir8}, 64'd0);
                if (c == 2) begin
                    held_s = s8; held_c = c8;
                    chk("t4_out_valid", {63'd0, ov8}, 64'd1);
                end else begin
                    chk("t4_sum_hold", {56'd0, s8}, {56'd0, held_s});
                    chk("t4_cout_hold", {63'd0, c8}, {63'd0, held_c});
                end
            end
        end
        chk("t4_sent", 64'(idx), 64'd4);
        idle(4);
        chk("t4_drained", 64'(q8.size()), 64'd0);

        // Reset with two items in flight.
        chk_lat = 1'b1;
        drv8(1, 8'h11, 8'h22, 0, 0, 8'h33, 0, 0, acc);
        drv8(1, 8'h33, 8'h44, 0, 0, 8'h77, 0, 0, acc);
        @(posedge clk); #1;
        rst = 1'b1; iv8 = 1'b0; or8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; or8 = 1'b1;
        q8.delete();
        @(negedge clk);
        chk("t5_out_valid", {63'd0, ov8}, 64'd0);
        chk("t5_sum", {56'd0, s8}, 64'd0);
        chk("t5_cout", {63'd0, c8}, 64'd0);
        chk("t5_in_ready", {63'd0, ir8}, 64'd1);
        idle(5);
        drv8(1, 8'h40, 8'h3F, 0, 1, 8'h7F, 0, 0, acc);
        idle(4);

        // Random traffic with random backpressure on both widths.
        chk_lat = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(posedge clk); #1;
            iv8  = ($urandom_range(0, 3) != 0); a8  = 8'($urandom); b8  = 8'($urandom); sub8  = 1'($urandom);
            or8  = ($urandom_range(0, 3) != 0);
            iv32 = ($urandom_range(0, 3) != 0); a32 = $urandom;     b32 = $urandom;     sub32 = 1'($urandom);
            or32 = ($urandom_range(0, 3) != 0);
            e8_nx  = model({24'd0, a8}, {24'd0, b8}, sub8, 8);
            e32_nx = model(a32, b32, sub32, 32);
            @(negedge clk);
            push_both();
        end
        @(posedge clk); #1;
        iv8 = 1'b0; iv32 = 1'b0; or8 = 1'b1; or32 = 1'b1;
        repeat (6) @(posedge clk);

        // No backpressure: latency must be exact.
        chk_lat = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            iv8  = 1'($urandom); a8  = 8'($urandom); b8  = 8'($urandom); sub8  = 1'($urandom); or8  = 1'b1;
            iv32 = 1'($urandom); a32 = $urandom;     b32 = $urandom;     sub32 = 1'($urandom); or32 = 1'b1;
            e8_nx  = model({24'd0, a8}, {24'd0, b8}, sub8, 8);
            e32_nx = model(a32, b32, sub32, 32);
            @(negedge clk);
            push_both();
        end
        @(posedge clk); #1;
        iv8 = 1'b0; iv32 = 1'b0;

        n = 0;
        while ((q8.size() != 0 || q32.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain8", 64'(q8.size()), 64'd0);
        chk("drain32", 64'(q32.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
